// File: rtl/button_debounce_multi.sv
`timescale 1ns/1ps
// N-channel push-button conditioner: synchronise, debounce on a 1 kHz tick,
// and derive press/release/long-press/auto-repeat pulses per channel.
module button_debounce_multi #(
  parameter int unsigned N           = 4,
  parameter int unsigned ACTIVE_LOW  = 1,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200,
  parameter int unsigned REPEAT_EN   = 1,
  parameter int unsigned CW          = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pulse1kHz,
  input  logic [N-1:0] ButtonIn,
  output logic [N-1:0] ButtonLevel,
  output logic [N-1:0] ButtonPress,
  output logic [N-1:0] ButtonRelease,
  output logic [N-1:0] ButtonLong,
  output logic [N-1:0] ButtonRepeat
);

  // Raw level seen on an untouched key; also the synchroniser reset value.
  localparam logic [N-1:0]  IDLE_LVL    = {N{ACTIVE_LOW != 0}};
  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_MS - 1);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_MS - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_MS - 1);
  localparam longint unsigned CW_MAX    = (64'd1 << CW) - 64'd1;

  // Elaboration-time parameter sanity.
  if (N < 1 || N > 16) begin : g_bad_n
    $error("button_debounce_multi: N must be 1..16");
  end
  if (DEBOUNCE_MS < 1 || REPEAT_MS < 1 || LONG_MS <= DEBOUNCE_MS) begin : g_bad_ms
    $error("button_debounce_multi: invalid ms parameters");
  end
  if (longint'(DEBOUNCE_MS) > CW_MAX || longint'(LONG_MS) > CW_MAX ||
      longint'(REPEAT_MS) > CW_MAX) begin : g_bad_cw
    $error("button_debounce_multi: CW too narrow for ms parameters");
  end

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HELD     = 2'd1,
    ST_REPEAT   = 2'd2
  } state_t;

  logic [N-1:0]  r_sync1;
  logic [N-1:0]  r_sync2;
  logic          r_pulse_d;
  logic [N-1:0]  r_level;
  logic [N-1:0]  r_press;
  logic [N-1:0]  r_release;
  logic [N-1:0]  r_long;
  logic [N-1:0]  r_repeat;
  logic [CW-1:0] r_dcnt  [N];
  logic [CW-1:0] r_hcnt  [N];
  state_t        r_state [N];

  logic          w_tick;
  logic [N-1:0]  w_pressed;
  logic [N-1:0]  w_level_nxt;
  logic [N-1:0]  w_press_nxt;
  logic [N-1:0]  w_release_nxt;
  logic [N-1:0]  w_long_nxt;
  logic [N-1:0]  w_repeat_nxt;
  logic [CW-1:0] w_dcnt_nxt  [N];
  logic [CW-1:0] w_hcnt_nxt  [N];
  state_t        w_state_nxt [N];

  // Two-flop synchroniser per key and tick edge-detect history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= IDLE_LVL;
      r_sync2   <= IDLE_LVL;
      r_pulse_d <= 1'b0;
    end else begin
      r_sync1   <= ButtonIn;
      r_sync2   <= r_sync1;
      r_pulse_d <= pulse1kHz;
    end
  end

  // A tick held high for several clocks still counts as one ms.
  assign w_tick    = pulse1kHz & ~r_pulse_d;
  // Normalised key state: 1 = pressed regardless of board polarity.
  assign w_pressed = r_sync2 ^ IDLE_LVL;

  // Debounce: accept a new level after DEBOUNCE_MS consecutive ticks of mismatch.
  always_comb begin
    w_level_nxt   = r_level;
    w_press_nxt   = '0;
    w_release_nxt = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_dcnt_nxt[i] = r_dcnt[i];
      if (w_pressed[i] == r_level[i]) begin
        w_dcnt_nxt[i] = '0;
      end else if (w_tick) begin
        if (r_dcnt[i] == DEB_LAST) begin
          w_dcnt_nxt[i]    = '0;
          w_level_nxt[i]   = ~r_level[i];
          w_press_nxt[i]   = ~r_level[i];
          w_release_nxt[i] = r_level[i];
        end else begin
          w_dcnt_nxt[i] = r_dcnt[i] + CW'(1);
        end
      end
    end
  end

  // Hold FSM: long-press after LONG_MS, then repeat every REPEAT_MS; release has priority.
  always_comb begin
    w_long_nxt   = '0;
    w_repeat_nxt = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_state_nxt[i] = r_state[i];
      w_hcnt_nxt[i]  = r_hcnt[i];
      if (w_release_nxt[i]) begin
        w_state_nxt[i] = ST_RELEASED;
        w_hcnt_nxt[i]  = '0;
      end else begin
        case (r_state[i])
          ST_RELEASED: begin
            if (w_press_nxt[i]) begin
              w_state_nxt[i] = ST_HELD;
              w_hcnt_nxt[i]  = '0;
            end
          end
          ST_HELD: begin
            if (w_tick) begin
              if (r_hcnt[i] == LONG_LAST) begin
                w_long_nxt[i]  = 1'b1;
                w_hcnt_nxt[i]  = '0;
                w_state_nxt[i] = ST_REPEAT;
              end else begin
                w_hcnt_nxt[i] = r_hcnt[i] + CW'(1);
              end
            end
          end
          ST_REPEAT: begin
            if (REPEAT_EN == 0) begin
              w_hcnt_nxt[i] = '0;
            end else if (w_tick) begin
              if (r_hcnt[i] == REPEAT_LAST) begin
                w_repeat_nxt[i] = 1'b1;
                w_hcnt_nxt[i]   = '0;
              end else begin
                w_hcnt_nxt[i] = r_hcnt[i] + CW'(1);
              end
            end
          end
          default: begin
            w_state_nxt[i] = ST_RELEASED;
            w_hcnt_nxt[i]  = '0;
          end
        endcase
      end
    end
  end

  // Per-channel state, counters and registered output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      r_repeat  <= '0;
      for (int i = 0; i < int'(N); i++) begin
        r_dcnt[i]  <= '0;
        r_hcnt[i]  <= '0;
        r_state[i] <= ST_RELEASED;
      end
    end else begin
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
      r_repeat  <= w_repeat_nxt;
      for (int i = 0; i < int'(N); i++) begin
        r_dcnt[i]  <= w_dcnt_nxt[i];
        r_hcnt[i]  <= w_hcnt_nxt[i];
        r_state[i] <= w_state_nxt[i];
      end
    end
  end

  assign ButtonLevel   = r_level;
  assign ButtonPress   = r_press;
  assign ButtonRelease = r_release;
  assign ButtonLong    = r_long;
  assign ButtonRepeat  = r_repeat;

endmodule

// File: tb/tb_button_debounce_multi.sv
`timescale 1ns/1ps
// Directed bench: default-parameter instance plus a REPEAT_EN=0 instance fed a
// two-clock-wide tick. One "ms" is TP clocks to keep the run short.
module tb_button_debounce_multi;

  localparam int TP = 8;

  logic       clk;
  logic       reset;
  logic       pulse_a;
  logic       pulse_b;
  logic [3:0] btn_a, btn_b;
  logic [3:0] lvl_a, prs_a, rel_a, lng_a, rpt_a;
  logic [3:0] lvl_b, prs_b, rel_b, lng_b, rpt_b;

  int ms_now = 0;
  int cyc    = 0;
  int n_checks = 0;
  int n_errors = 0;

  int cnt_prs_a [4];
  int cnt_rel_a [4];
  int cnt_lng_a [4];
  int cnt_rpt_a [4];
  int t_prs_a   [4];
  int t_rel_a   [4];
  int t_lng_a   [4];
  int t_rpt0_a  [4];
  int t_rptn_a  [4];
  int c_prs_a   [4];
  int cnt_prs_b = 0, cnt_rel_b = 0, cnt_lng_b = 0, cnt_rpt_b = 0, n_other_b = 0;
  int t_prs_b = 0, t_rel_b = 0, t_lng_b = 0;

  button_debounce_multi u_dut (
    .clk(clk), .reset(reset), .pulse1kHz(pulse_a), .ButtonIn(btn_a),
    .ButtonLevel(lvl_a), .ButtonPress(prs_a), .ButtonRelease(rel_a),
    .ButtonLong(lng_a), .ButtonRepeat(rpt_a)
  );

  button_debounce_multi #(.REPEAT_EN(0)) u_dut_nr (
    .clk(clk), .reset(reset), .pulse1kHz(pulse_b), .ButtonIn(btn_b),
    .ButtonLevel(lvl_b), .ButtonPress(prs_b), .ButtonRelease(rel_b),
    .ButtonLong(lng_b), .ButtonRepeat(rpt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick generator: A gets a 1-clock pulse, B a 2-clock pulse, same rising edge.
  initial begin
    pulse_a = 1'b0;
    pulse_b = 1'b0;
    forever begin
      for (int ph = 0; ph < TP; ph++) begin
        @(negedge clk);
        pulse_a = (ph == 0);
        pulse_b = (ph < 2);
      end
    end
  end

  // ms timestamp advances on the same edge the DUT sees the tick.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pulse_a) ms_now <= ms_now + 1;
  end

  // Event recorder, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (prs_a[i] === 1'b1) begin
        cnt_prs_a[i] <= cnt_prs_a[i] + 1;
        t_prs_a[i]   <= ms_now;
        c_prs_a[i]   <= cyc;
      end
      if (rel_a[i] === 1'b1) begin
        cnt_rel_a[i] <= cnt_rel_a[i] + 1;
        t_rel_a[i]   <= ms_now;
      end
      if (lng_a[i] === 1'b1) begin
        cnt_lng_a[i] <= cnt_lng_a[i] + 1;
        t_lng_a[i]   <= ms_now;
      end
      if (rpt_a[i] === 1'b1) begin
        cnt_rpt_a[i] <= cnt_rpt_a[i] + 1;
        if (cnt_rpt_a[i] == 0) t_rpt0_a[i] <= ms_now;
        t_rptn_a[i] <= ms_now;
      end
    end
    if (prs_b[0] === 1'b1) begin cnt_prs_b <= cnt_prs_b + 1; t_prs_b <= ms_now; end
    if (rel_b[0] === 1'b1) begin cnt_rel_b <= cnt_rel_b + 1; t_rel_b <= ms_now; end
    if (lng_b[0] === 1'b1) begin cnt_lng_b <= cnt_lng_b + 1; t_lng_b <= ms_now; end
    if (|rpt_b === 1'b1)   cnt_rpt_b <= cnt_rpt_b + 1;
    if (|{prs_b[3:1], rel_b[3:1], lng_b[3:1]} === 1'b1) n_other_b <= n_other_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ms_to(input int t);
    while (ms_now < t) @(negedge clk);
  endtask

  // 5 ms of chatter ending on a short return to the old level, then a clean edge.
  task automatic bounce_to(input int ch, input logic new_lvl, output int t_edge);
    for (int k = 0; k < 5 * TP; k++) begin
      btn_a[ch] = ((k % 4) < 2) ? new_lvl : ~new_lvl;
      @(negedge clk);
    end
    btn_a[ch] = ~new_lvl;
    repeat (3) @(negedge clk);
    t_edge    = ms_now;
    btn_a[ch] = new_lvl;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t0, t1, te, tr, tg, tl, tm, tq;
    reset = 1'b1;
    btn_a = 4'hF;
    btn_b = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_outs_a", {lvl_a, prs_a, rel_a, lng_a, rpt_a}, 0);
    check("reset_outs_b", {lvl_b, prs_b, rel_b, lng_b, rpt_b}, 0);
    reset = 1'b0;
    wait_ms_to(ms_now + 1);

    // Clean press and release on channel 0.
    t0 = ms_now;
    btn_a[0] = 1'b0;
    wait_ms_to(t0 + 60);
    check("press0_cnt", cnt_prs_a[0], 1);
    check("press0_time", t_prs_a[0], t0 + 20);
    check("level_after_press0", lvl_a, 4'b0001);
    check("press_other_cnt", cnt_prs_a[1] + cnt_prs_a[2] + cnt_prs_a[3], 0);
    t1 = ms_now;
    btn_a[0] = 1'b1;
    wait_ms_to(t1 + 30);
    check("release0_cnt", cnt_rel_a[0], 1);
    check("release0_time", t_rel_a[0], t1 + 20);
    check("level_after_rel0", lvl_a, 4'b0000);
    check("long0_cnt", cnt_lng_a[0], 0);

    // Bounce rejection on channel 1.
    bounce_to(1, 1'b0, te);
    wait_ms_to(te + 40);
    check("level_bounce1_held", lvl_a, 4'b0010);
    bounce_to(1, 1'b1, tr);
    wait_ms_to(tr + 30);
    check("press1_cnt", cnt_prs_a[1], 1);
    check("press1_time", t_prs_a[1], te + 20);
    check("release1_cnt", cnt_rel_a[1], 1);
    check("release1_time", t_rel_a[1], tr + 20);

    // 15 ms glitch on channel 2 is rejected.
    tg = ms_now;
    btn_a[2] = 1'b0;
    wait_ms_to(tg + 15);
    btn_a[2] = 1'b1;
    wait_ms_to(tg + 45);
    check("glitch2_press", cnt_prs_a[2], 0);
    check("glitch2_release", cnt_rel_a[2], 0);
    check("glitch2_level", lvl_a, 4'b0000);

    // Long press / auto-repeat (A ch3) and wide tick with repeat disabled (B ch0).
    tl = ms_now;
    btn_a[3] = 1'b0;
    btn_b[0] = 1'b0;
    wait_ms_to(tl + 1500);
    btn_b[0] = 1'b1;
    wait_ms_to(tl + 1700);
    btn_a[3] = 1'b1;
    wait_ms_to(tl + 1760);
    check("press3_time", t_prs_a[3], tl + 20);
    check("long3_cnt", cnt_lng_a[3], 1);
    check("long3_time", t_lng_a[3], tl + 1020);
    check("repeat3_cnt", cnt_rpt_a[3], 3);
    check("repeat3_first", t_rpt0_a[3], tl + 1220);
    check("repeat3_last", t_rptn_a[3], tl + 1620);
    check("release3_cnt", cnt_rel_a[3], 1);
    check("release3_time", t_rel_a[3], tl + 1720);
    check("b_press_cnt", cnt_prs_b, 1);
    check("b_press_time", t_prs_b, tl + 20);
    check("b_long_cnt", cnt_lng_b, 1);
    check("b_long_time", t_lng_b, tl + 1020);
    check("b_repeat_cnt", cnt_rpt_b, 0);
    check("b_release_time", t_rel_b, tl + 1520);
    check("b_release_cnt", cnt_rel_b, 1);
    check("b_other_events", n_other_b, 0);

    // Simultaneous press on channels 0 and 2, then reset while held.
    tm = ms_now;
    btn_a[0] = 1'b0;
    btn_a[2] = 1'b0;
    wait_ms_to(tm + 25);
    check("multi_press0_cnt", cnt_prs_a[0], 2);
    check("multi_press0_time", t_prs_a[0], tm + 20);
    check("multi_press2_time", t_prs_a[2], tm + 20);
    check("multi_same_cycle", c_prs_a[2], c_prs_a[0]);
    check("multi_level", lvl_a, 4'b0101);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tq = ms_now;
    check("midreset_outs", {lvl_a, prs_a, rel_a, lng_a, rpt_a}, 0);
    wait_ms_to(tq + 40);
    check("repress0_cnt", cnt_prs_a[0], 3);
    check("repress2_cnt", cnt_prs_a[2], 2);
    check("repress0_time", t_prs_a[0], tq + 20);
    check("repress2_time", t_prs_a[2], tq + 20);
    check("no_release0", cnt_rel_a[0], 1);
    check("no_release2", cnt_rel_a[2], 0);
    check("repress_level", lvl_a, 4'b0101);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_debounce_multi.md
Name: button_debounce_multi

Overview:
- Parametrised N-channel successor to the single-button debouncer. Each channel synchronises a raw mechanical key and debounces it against the shared 1 kHz tick. It emits a debounced level, one-clock press and release pulses, a one-shot long-press pulse and optional auto-repeat pulses.
- Sits between the board push-buttons and the ISP control FSMs. Replaces per-button instances with a single block.

Parameters:
- N, 4, number of independent button channels (1..16)
- ACTIVE_LOW, 1, 1 = raw input idles high and a press drives it to 0; 0 = active-high
- DEBOUNCE_MS, 20, consecutive ms ticks of a stable new level required to accept it (>=1)
- LONG_MS, 1000, ms a press must be held before ButtonLong fires (> DEBOUNCE_MS)
- REPEAT_MS, 200, ms period of ButtonRepeat after ButtonLong (>=1)
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = ButtonRepeat tied to 0
- CW, 11, width of the per-channel ms counters; must hold max(DEBOUNCE_MS, LONG_MS, REPEAT_MS)

Ports:
- clk, input, 1, system clock
- reset, input, 1, synchronous active-high reset
- pulse1kHz, input, 1, 1 kHz tick from the clock divider, synchronous to clk; may be high for one or more clk cycles
- ButtonIn, input, N, raw asynchronous key inputs (bit i = channel i)
- ButtonLevel, output, N, debounced level, 1 = pressed, independent of ACTIVE_LOW
- ButtonPress, output, N, one-clk pulse on accepted press
- ButtonRelease, output, N, one-clk pulse on accepted release
- ButtonLong, output, N, one-clk pulse when a press has been held LONG_MS ms
- ButtonRepeat, output, N, one-clk pulse every REPEAT_MS ms after ButtonLong while still held

Behaviour:
- One clock and a synchronous, active-high reset. All state changes occur on the clk rising edge, and all outputs are registered.
- Reset: synchroniser flops load the idle level (1 if ACTIVE_LOW); all counters = 0; all outputs = 0; every channel in RELEASED. A reset mid-press discards the press; no Release pulse is produced.
- Input path: 2-flop synchroniser per bit, then polarity normalisation so that 1 = pressed.
- Tick: tick = pulse1kHz & ~pulse1kHz_d (rising-edge detect). A multi-cycle-high pulse counts once. pulse1kHz_d resets to 0.
- Debounce counter dcnt per channel:
  - If sync == ButtonLevel, dcnt <= 0.
  - Else, on tick, dcnt increments.
  - When dcnt == DEBOUNCE_MS-1 and a tick arrives while the mismatch persists, ButtonLevel toggles and dcnt <= 0.
  - Any bounce back to the current level clears dcnt, so the full interval restarts.
- Press and release pulses: ButtonPress[i] is high for exactly the one cycle following the edge on which ButtonLevel[i] goes 0->1. ButtonRelease[i] is the same for 1->0.
- Per-channel state machine:
  - RELEASED -> HELD on accepted press; hcnt <= 0.
  - HELD: on tick, hcnt++. When hcnt reaches LONG_MS-1 on a tick: pulse ButtonLong, hcnt <= 0, go to REPEAT.
  - REPEAT: on tick, hcnt++. When hcnt reaches REPEAT_MS-1 on a tick: pulse ButtonRepeat (only if REPEAT_EN), hcnt <= 0.
  - With REPEAT_EN=0, hcnt saturates at 0 in REPEAT.
  - Any state -> RELEASED on accepted release; hcnt <= 0.
- Hold timing: hcnt counts from the press acceptance, not from the raw edge. Long fires LONG_MS ticks after ButtonPress.
- Release in the same cycle as a Long or Repeat terminal count: the release wins, and no Long/Repeat pulse is emitted.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Counters never wrap: dcnt is bounded by DEBOUNCE_MS-1, and hcnt by max(LONG_MS, REPEAT_MS)-1.
- Latency from a clean raw edge to the pulse: 2 clk (sync) + DEBOUNCE_MS ticks (first tick partial) + 1 clk.

Test Plan:
- Clean press: default parameters, 1 MHz clk; after reset hold ButtonIn[0]=0 for 60 ms -> ButtonPress[0] single-cycle pulse 19–20 ms after the edge; ButtonLevel[0]=1; other channels stay 0.
- Bounce rejection: 5 ms of 10 µs toggling on ButtonIn[1], then stable low 40 ms, then 5 ms bounce back high -> exactly one ButtonPress[1] and one ButtonRelease[1]; each Level edge follows the last bounce by 20 ms.
- Glitch shorter than debounce: ButtonIn[2] low for 15 ms, then high -> no pulses; ButtonLevel[2] stays 0; dcnt returns to 0.
- Long and repeat: hold ButtonIn[3] low 1.7 s -> ButtonPress at ~20 ms; ButtonLong at press+1000 ms; ButtonRepeat at press+1200, +1400, +1600 ms; ButtonRelease ~20 ms after the release edge; no further repeats.
- Tick width and REPEAT_EN=0: pulse1kHz high for 2 clk per ms, REPEAT_EN=0, hold 1.5 s -> timing identical to the single-cycle tick case; one ButtonLong; zero ButtonRepeat.
- Reset mid-press and multichannel: press channels 0 and 2 in the same cycle -> simultaneous ButtonPress bits 0 and 2. Assert reset for 1 clk while held -> all outputs 0 next cycle and no Release pulse; re-press is accepted after 20 ms.
